nb_feed_ctrl: RTL and testbench

- Upstream sequencer for the graph-conv `layer` stage.
- Per accepted event, it takes a count of neighbours and consumes that many neighbour addresses from a stream.
- It fetches each neighbour's feature vector from the feature memory and presents it to `layer` with the `is_neighbor` handshake.
- It then drives the `no_neighbor` aggregation phase and the `clean` pulse, and signals event completion.

---
 rtl/nb_feed_ctrl.sv | 158 +++++++++++++++
 tb/tb_nb_feed_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nb_feed_ctrl.sv
// Neighbour feed sequencer for the graph-conv layer stage: fetches one feature
// vector per neighbour address, hands it to the layer, then runs aggregation and clean.
package aegnn;
  localparam int unsigned F_WIDTH = 16;
endpackage

module nb_feed_ctrl #(
  parameter int unsigned IN_C        = 34,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_LATENCY = 2,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          ev_valid,
  output logic                          ev_ready,
  input  logic [CNT_W-1:0]              ev_nb_cnt,
  input  logic                          nb_valid,
  output logic                          nb_ready,
  input  logic [ADDR_W-1:0]             nb_addr,
  output logic                          mem_rd_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [IN_C*aegnn::F_WIDTH-1:0] mem_rdata,
  output logic                          is_neighbor,
  output logic                          no_neighbor,
  output logic                          clean,
  output logic [IN_C*aegnn::F_WIDTH-1:0] feature_in_pack,
  input  logic                          neighbor_done,
  input  logic                          conv_done,
  output logic                          ev_done,
  output logic                          busy
);

  localparam int unsigned DATA_W = IN_C * aegnn::F_WIDTH;
  localparam int unsigned LAT_W  = $clog2(MEM_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_FEED, S_GAP, S_AGGR, S_CLEAN
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q, remaining_d;
  logic [LAT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   feat_q, feat_d;
  logic                rd_en_q, rd_en_d;
  logic                ev_ready_q, ev_ready_d;
  logic                nb_ready_q, nb_ready_d;
  logic                is_nb_q, is_nb_d;
  logic                no_nb_q, no_nb_d;
  logic                clean_q, clean_d;
  logic                busy_q, busy_d;

  // Next state, datapath updates and registered outputs derived from the next state
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    mem_addr_d  = mem_addr_q;
    feat_d      = feat_q;
    rd_en_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ev_valid && ev_ready_q) begin
          remaining_d = ev_nb_cnt;
          state_d     = (ev_nb_cnt == '0) ? S_AGGR : S_FETCH;
        end
      end
      S_FETCH: begin
        if (nb_valid && nb_ready_q) begin
          rd_en_d    = 1'b1;
          mem_addr_d = nb_addr;
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // wait_cnt_q is 0 in the strobe cycle, so data is valid when it reaches MEM_LATENCY
        if (wait_cnt_q == LAT_W'(MEM_LATENCY)) begin
          feat_d  = mem_rdata;
          state_d = S_FEED;
        end else begin
          wait_cnt_d = wait_cnt_q + LAT_W'(1);
        end
      end
      S_FEED: begin
        if (neighbor_done) begin
          remaining_d = remaining_q - CNT_W'(1);
          state_d     = S_GAP;
        end
      end
      S_GAP: begin
        state_d = (remaining_q == '0) ? S_AGGR : S_FETCH;
      end
      S_AGGR: begin
        if (conv_done) begin
          state_d = S_CLEAN;
        end
      end
      S_CLEAN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ev_ready_d = (state_d == S_IDLE);
    nb_ready_d = (state_d == S_FETCH);
    is_nb_d    = (state_d == S_FEED);
    no_nb_d    = (state_d == S_AGGR);
    clean_d    = (state_d == S_CLEAN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      wait_cnt_q  <= '0;
      mem_addr_q  <= '0;
      feat_q      <= '0;
      rd_en_q     <= 1'b0;
      ev_ready_q  <= 1'b1;
      nb_ready_q  <= 1'b0;
      is_nb_q     <= 1'b0;
      no_nb_q     <= 1'b0;
      clean_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_addr_q  <= mem_addr_d;
      feat_q      <= feat_d;
      rd_en_q     <= rd_en_d;
      ev_ready_q  <= ev_ready_d;
      nb_ready_q  <= nb_ready_d;
      is_nb_q     <= is_nb_d;
      no_nb_q     <= no_nb_d;
      clean_q     <= clean_d;
      busy_q      <= busy_d;
    end
  end

  assign ev_ready        = ev_ready_q;
  assign nb_ready        = nb_ready_q;
  assign mem_rd_en       = rd_en_q;
  assign mem_addr        = mem_addr_q;
  assign is_neighbor     = is_nb_q;
  assign no_neighbor     = no_nb_q;
  assign clean           = clean_q;
  assign ev_done         = clean_q;
  assign feature_in_pack = feat_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_nb_feed_ctrl.sv
// Directed bench for nb_feed_ctrl with a fixed-latency feature memory model.
module tb_nb_feed_ctrl;

  localparam int unsigned IN_C   = 34;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LAT    = 2;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned FW     = aegnn::F_WIDTH;
  localparam int unsigned DW     = IN_C * FW;

  logic              clk, rstn;
  logic              ev_valid, ev_ready;
  logic [CNT_W-1:0]  ev_nb_cnt;
  logic              nb_valid, nb_ready;
  logic [ADDR_W-1:0] nb_addr;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DW-1:0]     mem_rdata;
  logic              is_neighbor, no_neighbor, clean;
  logic [DW-1:0]     feature_in_pack;
  logic              neighbor_done, conv_done, ev_done, busy;

  int checks = 0;
  int errors = 0;

  nb_feed_ctrl #(.IN_C(IN_C), .ADDR_W(ADDR_W), .MEM_LATENCY(LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_nb_cnt(ev_nb_cnt),
    .nb_valid(nb_valid), .nb_ready(nb_ready), .nb_addr(nb_addr),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .is_neighbor(is_neighbor), .no_neighbor(no_neighbor), .clean(clean),
    .feature_in_pack(feature_in_pack),
    .neighbor_done(neighbor_done), .conv_done(conv_done),
    .ev_done(ev_done), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Feature word per address; element 0 sits in the low bits
  function automatic logic [DW-1:0] vec_for(input logic [ADDR_W-1:0] a);
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < int'(IN_C); k++) begin
      case (a)
        12'h005: v[k*FW +: FW] = FW'(k + 1);
        12'h006: v[k*FW +: FW] = FW'(34 - k);
        12'h007: v[k*FW +: FW] = FW'(k + 100);
        default: v[k*FW +: FW] = FW'(3 * k + 7);
      endcase
    end
    return v;
  endfunction

  // Memory: data valid exactly LAT cycles after the strobe cycle, junk otherwise
  logic              pipe_en   [LAT];
  logic [ADDR_W-1:0] pipe_addr [LAT];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < int'(LAT); i++) pipe_en[i] <= 1'b0;
    end else begin
      pipe_en[0]   <= mem_rd_en;
      pipe_addr[0] <= mem_addr;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_en[i]   <= pipe_en[i-1];
        pipe_addr[i] <= pipe_addr[i-1];
      end
    end
  end
  always_comb begin
    mem_rdata = {17{32'hDEADBEEF}};
    if (pipe_en[LAT-1] === 1'b1) mem_rdata = vec_for(pipe_addr[LAT-1]);
  end

  // Observers: strobe log, is_neighbor rises, data stability while is_neighbor
  int              rd_cnt = 0, nb_rises = 0, stab_err = 0, done_cnt = 0;
  logic [ADDR_W-1:0] rd_log[$];
  logic            prev_is_nb = 1'b0;
  logic [DW-1:0]   prev_feat;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_is_nb <= 1'b0;
    end else begin
      if (mem_rd_en === 1'b1) begin
        rd_cnt <= rd_cnt + 1;
        rd_log.push_back(mem_addr);
      end
      if (is_neighbor === 1'b1 && prev_is_nb !== 1'b1) nb_rises <= nb_rises + 1;
      if (is_neighbor === 1'b1 && prev_is_nb === 1'b1 && feature_in_pack !== prev_feat)
        stab_err <= stab_err + 1;
      if (ev_done === 1'b1) done_cnt <= done_cnt + 1;
      prev_is_nb <= is_neighbor;
      prev_feat  <= feature_in_pack;
    end
  end

  function automatic logic sig_val(input int which);
    case (which)
      0: return is_neighbor;
      1: return no_neighbor;
      2: return ev_done;
      3: return nb_ready;
      default: return ev_ready;
    endcase
  endfunction

  // Bounded wait at negedges; caller turns a timeout into a failed comparison
  task automatic wait_for(input int which, input logic lvl, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (sig_val(which) === lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_event(input logic [CNT_W-1:0] cnt);
    ev_valid  = 1'b1;
    ev_nb_cnt = cnt;
    @(negedge clk);
    ev_valid  = 1'b0;
    ev_nb_cnt = ~cnt;
  endtask

  task automatic feed_one(input logic [ADDR_W-1:0] addr, input int stall, input int layer);
    bit ok;
    wait_for(3, 1'b1, 50, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL nb_ready_wait addr=%h timed out", addr); end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (nb_ready !== 1'b1 || mem_rd_en !== 1'b0 || is_neighbor !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d got nb_ready=%b rd_en=%b is_nb=%b want 1 0 0",
                 i, nb_ready, mem_rd_en, is_neighbor);
      end
    end
    nb_valid = 1'b1;
    nb_addr  = addr;
    @(negedge clk);
    nb_valid = 1'b0;
    nb_addr  = 12'h3FF;
    checks++;
    if (mem_rd_en !== 1'b1 || mem_addr !== addr) begin
      errors++;
      $display("FAIL rd_strobe got en=%b addr=%h want 1 %h", mem_rd_en, mem_addr, addr);
    end
    wait_for(0, 1'b1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL is_neighbor_wait addr=%h timed out", addr); end
    checks++;
    if (feature_in_pack !== vec_for(addr)) begin
      errors++;
      $display("FAIL feature addr=%h got %h want %h", addr, feature_in_pack, vec_for(addr));
    end
    repeat (layer) @(negedge clk);
    neighbor_done = 1'b1;
    @(negedge clk);
    neighbor_done = 1'b0;
    checks++;
    if (is_neighbor !== 1'b0) begin
      errors++; $display("FAIL gap_low got is_nb=%b want 0", is_neighbor);
    end
  endtask

  task automatic finish_event();
    bit ok;
    wait_for(1, 1'b1, 20, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL no_neighbor_wait timed out"); end
    repeat (3) @(negedge clk);
    conv_done = 1'b1;
    ev_valid  = 1'b0;
    @(negedge clk);
    conv_done = 1'b0;
    checks++;
    if (clean !== 1'b1 || ev_done !== 1'b1 || no_neighbor !== 1'b0) begin
      errors++;
      $display("FAIL clean_pulse got clean=%b ev_done=%b no_nb=%b want 1 1 0",
               clean, ev_done, no_neighbor);
    end
    @(negedge clk);
    checks++;
    if (clean !== 1'b0 || ev_done !== 1'b0 || ev_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL back_idle got clean=%b ev_done=%b ev_ready=%b busy=%b want 0 0 1 0",
               clean, ev_done, ev_ready, busy);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ev_valid = 1'b0; ev_nb_cnt = '0; nb_valid = 1'b0; nb_addr = '0;
    neighbor_done = 1'b0; conv_done = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1 || busy !== 1'b0 || nb_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs got ev_ready=%b busy=%b nb_ready=%b want 1 0 0", ev_ready, busy, nb_ready);
    end
    checks++;
    if ({mem_rd_en, is_neighbor, no_neighbor, clean, ev_done} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000",
               {mem_rd_en, is_neighbor, no_neighbor, clean, ev_done});
    end
    checks++;
    if (feature_in_pack !== '0 || mem_addr !== '0) begin
      errors++; $display("FAIL reset_data got addr=%h feat=%h want 0", mem_addr, feature_in_pack);
    end
    rstn = 1'b1;
  endtask

  task automatic test_single();
    int rd0 = rd_cnt, dn0 = done_cnt;
    start_event(5'd1);
    feed_one(12'h005, 0, 39);
    @(negedge clk);
    checks++;
    if (no_neighbor !== 1'b1) begin
      errors++; $display("FAIL single_aggr got no_nb=%b want 1", no_neighbor);
    end
    finish_event();
    checks++;
    if (rd_cnt - rd0 !== 1 || rd_log[rd_log.size()-1] !== 12'h005) begin
      errors++; $display("FAIL single_rd got %0d reads want 1 at 005", rd_cnt - rd0);
    end
    checks++;
    if (done_cnt - dn0 !== 1 || stab_err !== 0) begin
      errors++;
      $display("FAIL single_done got done=%0d stab_err=%0d want 1 0", done_cnt - dn0, stab_err);
    end
  endtask

  task automatic test_two();
    int rd0 = rd_cnt, dn0 = done_cnt, ri0 = nb_rises;
    start_event(5'd2);
    feed_one(12'h005, 0, 6);
    feed_one(12'h006, 0, 0);
    @(negedge clk);
    checks++;
    if (no_neighbor !== 1'b1 || dut.remaining_q !== 5'd0) begin
      errors++;
      $display("FAIL two_remaining got no_nb=%b remaining=%0d want 1 0", no_neighbor, dut.remaining_q);
    end
    finish_event();
    checks++;
    if (rd_cnt - rd0 !== 2 || rd_log[rd_log.size()-2] !== 12'h005 || rd_log[rd_log.size()-1] !== 12'h006) begin
      errors++; $display("FAIL two_order got %0d reads want 005 then 006", rd_cnt - rd0);
    end
    checks++;
    if (nb_rises - ri0 !== 2 || done_cnt - dn0 !== 1) begin
      errors++;
      $display("FAIL two_pulses got rises=%0d done=%0d want 2 1", nb_rises - ri0, done_cnt - dn0);
    end
  endtask

  task automatic test_zero();
    int rd0 = rd_cnt;
    start_event(5'd0);
    checks++;
    if (no_neighbor !== 1'b1 || nb_ready !== 1'b0 || mem_rd_en !== 1'b0) begin
      errors++;
      $display("FAIL zero_aggr got no_nb=%b nb_ready=%b rd_en=%b want 1 0 0",
               no_neighbor, nb_ready, mem_rd_en);
    end
    finish_event();
    checks++;
    if (rd_cnt !== rd0) begin errors++; $display("FAIL zero_reads got %0d want 0", rd_cnt - rd0); end
  endtask

  task automatic test_stall();
    int rd0 = rd_cnt, dn0 = done_cnt;
    start_event(5'd2);
    feed_one(12'h006, 0, 3);
    feed_one(12'h005, 20, 3);
    finish_event();
    checks++;
    if (rd_cnt - rd0 !== 2 || done_cnt - dn0 !== 1) begin
      errors++;
      $display("FAIL stall_totals got reads=%0d done=%0d want 2 1", rd_cnt - rd0, done_cnt - dn0);
    end
  endtask

  task automatic test_spurious();
    bit ok;
    int dn0 = done_cnt;
    start_event(5'd1);
    wait_for(3, 1'b1, 20, ok);
    nb_valid = 1'b1; nb_addr = 12'h006;
    @(negedge clk);
    nb_valid = 1'b0;
    neighbor_done = 1'b1;
    ev_valid = 1'b1; ev_nb_cnt = 5'd0;
    @(negedge clk);
    neighbor_done = 1'b0;
    checks++;
    if (busy !== 1'b1 || ev_ready !== 1'b0 || is_neighbor !== 1'b0 || no_neighbor !== 1'b0) begin
      errors++;
      $display("FAIL spur_wait got busy=%b ev_ready=%b is_nb=%b no_nb=%b want 1 0 0 0",
               busy, ev_ready, is_neighbor, no_neighbor);
    end
    wait_for(0, 1'b1, 20, ok);
    checks++;
    if (!ok || feature_in_pack !== vec_for(12'h006)) begin
      errors++; $display("FAIL spur_feed got ok=%b feat=%h", ok, feature_in_pack);
    end
    conv_done = 1'b1;
    @(negedge clk);
    conv_done = 1'b0;
    @(negedge clk);
    checks++;
    if (is_neighbor !== 1'b1 || no_neighbor !== 1'b0 || ev_ready !== 1'b0) begin
      errors++;
      $display("FAIL spur_conv got is_nb=%b no_nb=%b ev_ready=%b want 1 0 0",
               is_neighbor, no_neighbor, ev_ready);
    end
    neighbor_done = 1'b1;
    @(negedge clk);
    neighbor_done = 1'b0;
    finish_event();
    checks++;
    if (done_cnt - dn0 !== 1) begin
      errors++; $display("FAIL spur_events got %0d ev_done want 1", done_cnt - dn0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int dn0 = done_cnt;
    start_event(5'd0);
    wait_for(1, 1'b1, 10, ok);
    conv_done = 1'b1;
    ev_valid = 1'b1; ev_nb_cnt = 5'd0;
    @(negedge clk);
    conv_done = 1'b0;
    checks++;
    if (clean !== 1'b1 || ev_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_clean got clean=%b ev_ready=%b want 1 0", clean, ev_ready);
    end
    @(negedge clk);
    checks++;
    if (ev_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle got ev_ready=%b want 1", ev_ready); end
    @(negedge clk);
    ev_valid = 1'b0;
    checks++;
    if (no_neighbor !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_accept got no_nb=%b busy=%b want 1 1", no_neighbor, busy);
    end
    finish_event();
    checks++;
    if (done_cnt - dn0 !== 2) begin
      errors++; $display("FAIL b2b_events got %0d want 2", done_cnt - dn0);
    end
  endtask

  task automatic test_max_count();
    int rd0 = rd_cnt, dn0 = done_cnt;
    start_event(5'd31);
    for (int n = 0; n < 31; n++) feed_one((n % 2 == 0) ? 12'h005 : 12'h006, 0, 0);
    finish_event();
    checks++;
    if (rd_cnt - rd0 !== 31 || done_cnt - dn0 !== 1 || stab_err !== 0) begin
      errors++;
      $display("FAIL max_count got reads=%0d done=%0d stab=%0d want 31 1 0",
               rd_cnt - rd0, done_cnt - dn0, stab_err);
    end
  endtask

  task automatic test_reset_mid_feed();
    bit ok;
    start_event(5'd1);
    wait_for(3, 1'b1, 20, ok);
    nb_valid = 1'b1; nb_addr = 12'h006;
    @(negedge clk);
    nb_valid = 1'b0;
    wait_for(0, 1'b1, 20, ok);
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (is_neighbor !== 1'b0 || no_neighbor !== 1'b0 || clean !== 1'b0 || ev_ready !== 1'b1 ||
        busy !== 1'b0 || feature_in_pack !== '0) begin
      errors++;
      $display("FAIL async_reset got is_nb=%b no_nb=%b clean=%b ev_ready=%b busy=%b",
               is_neighbor, no_neighbor, clean, ev_ready, busy);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    start_event(5'd1);
    feed_one(12'h007, 0, 4);
    finish_event();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    @(negedge clk);
    test_single();
    test_two();
    test_zero();
    test_stall();
    test_spurious();
    test_back_to_back();
    test_max_count();
    test_reset_mid_feed();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
